// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums COUNT unsigned words from the upstream merge stage
// and holds each completed sum until the downstream side takes it.
module psum_accumulator #(
   parameter int WIDTH     = 8,
   parameter int COUNT     = 4,
   parameter int OUT_WIDTH = WIDTH + $clog2(COUNT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   input  logic                     clear,
   output logic                     out_valid,
   output logic [OUT_WIDTH-1:0]     out_data,
   input  logic                     out_ready,
   output logic [$clog2(COUNT):0]   word_cnt
);

   localparam int CNT_W = $clog2(COUNT) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [OUT_WIDTH-1:0]   acc;
   logic [OUT_WIDTH-1:0]   acc_next;
   logic [CNT_W-1:0]       cnt_next;
   logic [OUT_WIDTH-1:0]   out_data_next;
   logic                   out_valid_next;

   function automatic logic [OUT_WIDTH-1:0] add_word(
      input logic [OUT_WIDTH-1:0] sum,
      input logic [WIDTH-1:0]     word
   );
      return sum + OUT_WIDTH'(word);
   endfunction

   // Ready depends on state alone so upstream never sees a path from its own valid.
   assign in_ready = (state == ACCUM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         word_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_next;
         acc       <= acc_next;
         word_cnt  <= cnt_next;
         out_valid <= out_valid_next;
         out_data  <= out_data_next;
      end
   end

   always_comb begin
      state_next     = state;
      acc_next       = acc;
      cnt_next       = word_cnt;
      out_data_next  = out_data;
      out_valid_next = out_valid;
      case (state)
         ACCUM: begin
            // Clear takes priority, so a last word arriving with it never yields a result.
            if (clear) begin
               acc_next = '0;
               cnt_next = '0;
            end else if (in_valid) begin
               if (word_cnt == LAST_IDX) begin
                  out_data_next  = add_word(acc, in_data);
                  out_valid_next = 1'b1;
                  acc_next       = '0;
                  cnt_next       = '0;
                  state_next     = HOLD;
               end else begin
                  acc_next = add_word(acc, in_data);
                  cnt_next = word_cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               state_next     = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus throttled random traffic checked
// against a queue-based reference model of the accumulate/hold behaviour.
module tb_psum_accumulator;

   localparam int WIDTH = 8;
   localparam int COUNT = 4;
   localparam int OW    = WIDTH + $clog2(COUNT);
   localparam int CW    = $clog2(COUNT) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             clear = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [OW-1:0]    out_data;
   logic [CW-1:0]    word_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   psum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT), .OUT_WIDTH(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .clear     (clear),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .word_cnt  (word_cnt)
   );

   // Reference model: words collected so far toward the current result, and a pending result.
   int unsigned words[$];
   bit          m_hold;
   int unsigned m_data;

   function automatic int unsigned qsum(input int unsigned q[$]);
      int unsigned s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         words.delete();
         m_hold <= 1'b0;
         m_data <= 0;
      end else if (!m_hold) begin
         if (clear) begin
            words.delete();
         end else if (in_valid) begin
            if (words.size() == COUNT - 1) begin
               m_data <= qsum(words) + int'(in_data);
               m_hold <= 1'b1;
               words.delete();
            end else begin
               words.push_back(int'(in_data));
            end
         end
      end else if (out_ready) begin
         m_hold <= 1'b0;
      end
   end

   task automatic drive(input bit v, input int d, input bit c, input bit r);
      in_valid  = v;
      in_data   = WIDTH'(d);
      clear     = c;
      out_ready = r;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_checks++;
      if (word_cnt !== '0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d required 0", word_cnt); end
      n_checks++;
      if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_basic();
      int nv = 0;
      int ni = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (word_cnt !== CW'(i)) begin n_fail++; $display("FAIL basic_word_cnt: got %0d required %0d", word_cnt, i); end
         drive(1, i + 1, 0, 1);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (out_valid) begin
            nv++;
            n_checks++;
            if (out_data !== OW'(10)) begin n_fail++; $display("FAIL basic_sum: got %0d required 10", out_data); end
         end
         if (!in_ready) ni++;
         drive(0, 0, 0, 1);
      end
      n_checks++;
      if (nv != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d required 1", nv); end
      n_checks++;
      if (ni != 1) begin n_fail++; $display("FAIL basic_ready_low_cycles: got %0d required 1", ni); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 255, 0, 0);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b required 1", out_valid); end
         n_checks++;
         if (out_data !== OW'(1020)) begin n_fail++; $display("FAIL hold_data: got %0h required 3fc", out_data); end
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b required 0", in_ready); end
         drive(1, int'($urandom_range(0, 255)), 0, 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 1);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b required 0", out_valid); end
      n_checks++;
      if (word_cnt !== '0) begin n_fail++; $display("FAIL hold_ignored_input: word_cnt got %0d required 0", word_cnt); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b required 1", in_ready); end
   endtask

   task automatic test_clear();
      bit tv[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      int td[12] = '{5, 6, 7, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      bit tc[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      int nres = 0;
      int got  = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) begin nres++; got = int'(out_data); end
         if (i == 3) begin
            n_checks++;
            if (word_cnt !== '0) begin n_fail++; $display("FAIL clear_word_cnt: got %0d required 0", word_cnt); end
         end
         drive(tv[i], td[i], tc[i], 1);
      end
      n_checks++;
      if (nres != 1) begin n_fail++; $display("FAIL clear_result_count: got %0d required 1", nres); end
      n_checks++;
      if (got != 4) begin n_fail++; $display("FAIL clear_result_value: got %0d required 4", got); end
   endtask

   task automatic test_clear_hold();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, i + 1, 0, 0);
      end
      @(negedge clk);
      drive(1, 99, 1, 0);
      repeat (2) @(negedge clk);
      drive(0, 0, 0, 1);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_hold_valid: got %b required 1", out_valid); end
      n_checks++;
      if (out_data !== OW'(10)) begin n_fail++; $display("FAIL clear_hold_data: got %0d required 10", out_data); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_hold_taken: got %b required 0", out_valid); end
      n_checks++;
      if (word_cnt !== '0) begin n_fail++; $display("FAIL clear_hold_word_cnt: got %0d required 0", word_cnt); end
   endtask

   task automatic test_reset_mid();
      int nres = 0;
      int got  = -1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive(1, 9, 0, 1);
      end
      @(negedge clk);
      n_checks++;
      if (word_cnt !== CW'(2)) begin n_fail++; $display("FAIL rstmid_pre_cnt: got %0d required 2", word_cnt); end
      drive(0, 0, 0, 1);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b required 0", out_valid); end
      n_checks++;
      if (word_cnt !== '0) begin n_fail++; $display("FAIL rstmid_word_cnt: got %0d required 0", word_cnt); end
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin nres++; got = int'(out_data); end
         drive(i < 4, 2, 0, 1);
      end
      n_checks++;
      if (nres != 1 || got != 8) begin n_fail++; $display("FAIL rstmid_result: got %0d results last %0d required 1 result 8", nres, got); end
      // Reset while a result is pending must drop it without any later handshake.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 3, 0, 0);
      end
      @(negedge clk);
      drive(0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rsthold_pending: got %b required 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL rsthold_drop: got valid %b data %0d required 0 0", out_valid, out_data); end
      #1 rst = 1'b0;
      drive(0, 0, 0, 1);
      nres = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) nres++;
      end
      n_checks++;
      if (nres != 0) begin n_fail++; $display("FAIL rsthold_no_output: got %0d valid cycles required 0", nres); end
   endtask

   task automatic test_random();
      int results = 0;
      int cycles  = 0;
      bit v, r, c;
      drive(0, 0, 0, 1);
      while (results < 1000 && cycles < 60000) begin
         @(negedge clk);
         cycles++;
         n_checks++;
         if (out_valid !== m_hold) begin n_fail++; $display("FAIL rand_valid: got %b required %b cycle %0d", out_valid, m_hold, cycles); end
         if (m_hold) begin
            n_checks++;
            if (out_data !== OW'(m_data)) begin n_fail++; $display("FAIL rand_data: got %0d required %0d cycle %0d", out_data, m_data, cycles); end
         end
         n_checks++;
         if (in_ready !== !m_hold) begin n_fail++; $display("FAIL rand_in_ready: got %b required %b cycle %0d", in_ready, !m_hold, cycles); end
         n_checks++;
         if (word_cnt !== CW'(words.size())) begin n_fail++; $display("FAIL rand_word_cnt: got %0d required %0d cycle %0d", word_cnt, words.size(), cycles); end
         v = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 99) < 60);
         c = ($urandom_range(0, 99) < 2);
         drive(v, int'($urandom_range(0, 255)), c, r);
         if (out_valid && r) results++;
      end
      n_checks++;
      if (results < 1000) begin n_fail++; $display("FAIL rand_timeout: got %0d results required 1000", results); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_clear();
      test_clear_hold();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
